// File: rtl/sync_pulse_pkg.sv
// ---------------------------------------------------------------------------
// sync_pulse_pkg
// Shared constants and helpers for the sync_pulse_capture block.
//   EDGE_RISE / EDGE_FALL / EDGE_BOTH : encodings of the EDGE_SEL parameter
//   stab_width()                      : width of the glitch-filter counter
// ---------------------------------------------------------------------------
package sync_pulse_pkg;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;

  // The counter must be able to hold 0 .. FILT_LEN, so it needs
  // clog2(FILT_LEN+1) bits. Illegal lengths fall back to one bit so the
  // elaboration check, not a zero-width vector, reports the problem.
  function automatic int stab_width(input int filt_len);
    if (filt_len < 1) begin
      return 1;
    end else begin
      return $clog2(filt_len + 1);
    end
  endfunction

endpackage : sync_pulse_pkg

// File: rtl/sync_pulse_capture_glitch_filter.sv
// ---------------------------------------------------------------------------
// glitch_filter
// Debounces the synchronized level: level_filt only follows sig_sync once
// sig_sync has disagreed with it for FILT_LEN consecutive clk_fast samples.
// Ports:
//   clk_fast   in  fast-domain clock
//   rst_n      in  asynchronous active-low reset
//   sig_sync   in  synchronized input level
//   level_filt out filtered level (registered)
//   toggle     out high in the cycle whose closing edge flips level_filt
// ---------------------------------------------------------------------------
module glitch_filter
  import sync_pulse_pkg::*;
#(
  parameter int FILT_LEN = 3
) (
  input  logic clk_fast,
  input  logic rst_n,
  input  logic sig_sync,
  output logic level_filt,
  output logic toggle
);

  localparam int SW = stab_width(FILT_LEN);
  localparam logic [SW-1:0] STAB_LAST = SW'(FILT_LEN - 1);
  localparam logic [SW-1:0] STAB_ONE  = SW'(1);

  if (FILT_LEN < 1) begin : g_filt_len_chk
    $error("glitch_filter: FILT_LEN must be >= 1");
  end

  logic [SW-1:0] r_stab_cnt;
  logic          r_level;
  logic          w_differs;

  assign w_differs  = (sig_sync != r_level);
  // The FILT_LEN-th differing sample is the one currently presented while
  // the counter already holds FILT_LEN-1.
  assign toggle     = w_differs && (r_stab_cnt == STAB_LAST);
  assign level_filt = r_level;

  // Stability counter and filtered level.
  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      r_stab_cnt <= '0;
      r_level    <= 1'b0;
    end else if (!w_differs) begin
      r_stab_cnt <= '0;
    end else if (toggle) begin
      r_stab_cnt <= '0;
      r_level    <= ~r_level;
    end else begin
      r_stab_cnt <= r_stab_cnt + STAB_ONE;
    end
  end

endmodule : glitch_filter

// File: rtl/sync_pulse_capture.sv
// ---------------------------------------------------------------------------
// sync_pulse_capture
// Fast-domain consumer of a synchronized level. Filters glitches, produces
// one-cycle rise/fall pulses and queues selected edges in a saturating
// pending counter drained through a valid/ready handshake.
// Ports:
//   clk_fast, rst_n      clock / async active-low reset
//   sig_sync             synchronized level input
//   level_filt           filtered level
//   rise_pulse/fall_pulse one-cycle pulse in the first cycle of a new level
//   evt_valid/evt_ready  event handshake (evt_valid = evt_cnt != 0)
//   evt_cnt              pending-event count (saturates at 2^CNT_W-1)
//   overflow / ovf_clr   sticky drop flag and its synchronous clear
// ---------------------------------------------------------------------------
module sync_pulse_capture
  import sync_pulse_pkg::*;
#(
  parameter int FILT_LEN = 3,
  parameter int CNT_W    = 4,
  parameter int EDGE_SEL = 0
) (
  input  logic             clk_fast,
  input  logic             rst_n,
  input  logic             sig_sync,
  output logic             level_filt,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CNT_W-1:0] evt_cnt,
  output logic             overflow,
  input  logic             ovf_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  if ((EDGE_SEL < EDGE_RISE) || (EDGE_SEL > EDGE_BOTH)) begin : g_edge_sel_chk
    $error("sync_pulse_capture: EDGE_SEL must be 0, 1 or 2");
  end

  logic             w_level;
  logic             w_toggle;
  logic             r_rise;
  logic             r_fall;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic             w_inc;
  logic             w_dec;
  logic             w_drop;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_ovf_nxt;

  glitch_filter #(
    .FILT_LEN (FILT_LEN)
  ) u_filter (
    .clk_fast   (clk_fast),
    .rst_n      (rst_n),
    .sig_sync   (sig_sync),
    .level_filt (w_level),
    .toggle     (w_toggle)
  );

  assign level_filt = w_level;
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;
  assign evt_cnt    = r_cnt;
  assign overflow   = r_ovf;
  assign evt_valid  = (r_cnt != '0);
  assign w_dec      = evt_valid && evt_ready;

  // Event source: the registered pulses, so the count moves one cycle after
  // the pulse is visible.
  always_comb begin
    w_inc = 1'b0;
    case (EDGE_SEL)
      EDGE_RISE: w_inc = r_rise;
      EDGE_FALL: w_inc = r_fall;
      EDGE_BOTH: w_inc = r_rise || r_fall;
      default:   w_inc = 1'b0;
    endcase
  end

  // Next pending count and overflow; a drop at saturation beats ovf_clr.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_drop    = 1'b0;
    if (w_inc && !w_dec) begin
      if (r_cnt == CNT_MAX) begin
        w_drop = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + CNT_ONE;
      end
    end else if (!w_inc && w_dec) begin
      w_cnt_nxt = r_cnt - CNT_ONE;
    end else begin
      w_cnt_nxt = r_cnt;
    end

    if (w_drop) begin
      w_ovf_nxt = 1'b1;
    end else if (ovf_clr) begin
      w_ovf_nxt = 1'b0;
    end else begin
      w_ovf_nxt = r_ovf;
    end
  end

  // Pulse, counter and overflow registers.
  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      // Direction follows the pre-toggle level, so the pulse lands in the
      // first cycle of the new level.
      r_rise <= w_toggle && !w_level;
      r_fall <= w_toggle && w_level;
      r_cnt  <= w_cnt_nxt;
      r_ovf  <= w_ovf_nxt;
    end
  end

endmodule : sync_pulse_capture

// File: tb/tb_sync_pulse_capture.sv
// Bench for sync_pulse_capture: two instances (rise-only and both-edges)
// share one stimulus stream; a reference model predicts every cycle's outputs
// into per-instance queues and a monitor compares them on the falling edge.
module tb_sync_pulse_capture;

  localparam int FILT_LEN = 3;
  localparam int CNT_W    = 4;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  typedef struct packed {
    logic             lvl;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] cnt;
    logic             valid;
    logic             ovf;
  } exp_t;

  logic clk_fast = 1'b0;
  logic rst_n    = 1'b0;
  logic sig_sync = 1'b0;
  logic evt_ready = 1'b0;
  logic ovf_clr  = 1'b0;

  logic             d_lvl   [2];
  logic             d_rise  [2];
  logic             d_fall  [2];
  logic             d_valid [2];
  logic [CNT_W-1:0] d_cnt   [2];
  logic             d_ovf   [2];

  int n_checks = 0;
  int n_errors = 0;
  bit done = 1'b0;

  exp_t q0[$];
  exp_t q1[$];

  always #5 clk_fast = ~clk_fast;

  sync_pulse_capture #(.FILT_LEN(FILT_LEN), .CNT_W(CNT_W), .EDGE_SEL(0)) u_rise (
    .clk_fast(clk_fast), .rst_n(rst_n), .sig_sync(sig_sync),
    .level_filt(d_lvl[0]), .rise_pulse(d_rise[0]), .fall_pulse(d_fall[0]),
    .evt_valid(d_valid[0]), .evt_ready(evt_ready), .evt_cnt(d_cnt[0]),
    .overflow(d_ovf[0]), .ovf_clr(ovf_clr)
  );

  sync_pulse_capture #(.FILT_LEN(FILT_LEN), .CNT_W(CNT_W), .EDGE_SEL(2)) u_both (
    .clk_fast(clk_fast), .rst_n(rst_n), .sig_sync(sig_sync),
    .level_filt(d_lvl[1]), .rise_pulse(d_rise[1]), .fall_pulse(d_fall[1]),
    .evt_valid(d_valid[1]), .evt_ready(evt_ready), .evt_cnt(d_cnt[1]),
    .overflow(d_ovf[1]), .ovf_clr(ovf_clr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Filter rule: the level flips once the last FILT_LEN samples all disagree
  // with it. Counter rule: +1 per selected edge seen one cycle after the
  // pulse, -1 per accepted transfer, saturate with sticky overflow.
  int   m_cnt [2];
  logic m_ovf [2];
  logic m_lvl, m_rise, m_fall;
  logic hist[$];

  task automatic model_step();
    exp_t e;
    bit   all_diff;
    if (!rst_n) begin
      m_lvl = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
      hist.delete();
      for (int i = 0; i < FILT_LEN; i++) hist.push_back(1'b0);
      for (int d = 0; d < 2; d++) begin m_cnt[d] = 0; m_ovf[d] = 1'b0; end
    end else begin
      for (int d = 0; d < 2; d++) begin
        bit inc, dec, drop;
        dec  = (m_cnt[d] != 0) && (evt_ready == 1'b1);
        inc  = (d == 0) ? (m_rise == 1'b1) : (m_rise == 1'b1 || m_fall == 1'b1);
        drop = 1'b0;
        if (inc && !dec) begin
          if (m_cnt[d] == CNT_MAX) drop = 1'b1;
          else m_cnt[d]++;
        end else if (!inc && dec) begin
          m_cnt[d]--;
        end
        if (drop) m_ovf[d] = 1'b1;
        else if (ovf_clr) m_ovf[d] = 1'b0;
      end
      hist.push_back(sig_sync);
      if (hist.size() > FILT_LEN) void'(hist.pop_front());
      all_diff = 1'b1;
      foreach (hist[i]) if (hist[i] == m_lvl) all_diff = 1'b0;
      if (all_diff) begin
        m_lvl = ~m_lvl; m_rise = m_lvl; m_fall = ~m_lvl;
      end else begin
        m_rise = 1'b0; m_fall = 1'b0;
      end
    end
    for (int d = 0; d < 2; d++) begin
      e.lvl = m_lvl; e.rise = m_rise; e.fall = m_fall;
      e.cnt = CNT_W'(m_cnt[d]); e.valid = (m_cnt[d] != 0); e.ovf = m_ovf[d];
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk_fast);
      if (!done) model_step();
    end
  end

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_fast);
      for (int d = 0; d < 2; d++) begin
        if ((d == 0 && q0.size() > 0) || (d == 1 && q1.size() > 0)) begin
          e = (d == 0) ? q0.pop_front() : q1.pop_front();
          check($sformatf("sb dut%0d level_filt", d), 32'(d_lvl[d]),   32'(e.lvl));
          check($sformatf("sb dut%0d rise_pulse", d), 32'(d_rise[d]),  32'(e.rise));
          check($sformatf("sb dut%0d fall_pulse", d), 32'(d_fall[d]),  32'(e.fall));
          check($sformatf("sb dut%0d evt_cnt", d),    32'(d_cnt[d]),   32'(e.cnt));
          check($sformatf("sb dut%0d evt_valid", d),  32'(d_valid[d]), 32'(e.valid));
          check($sformatf("sb dut%0d overflow", d),   32'(d_ovf[d]),   32'(e.ovf));
        end
      end
    end
  end

  // Inputs change 2 time units after a rising edge and hold for n edges.
  task automatic drive(input logic s, input logic r, input logic c, input int n);
    sig_sync = s; evt_ready = r; ovf_clr = c;
    repeat (n) begin @(posedge clk_fast); #2; end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) @(posedge clk_fast);
    #2 rst_n = 1'b1;

    drive(1'b0, 1'b0, 1'b0, 3);
    // glitch of two samples is rejected
    drive(1'b1, 1'b0, 1'b0, 2);
    drive(1'b0, 1'b0, 1'b0, 4);
    check("glitch level_filt", 32'(d_lvl[0]), 32'd0);
    check("glitch evt_cnt",    32'(d_cnt[1]), 32'd0);

    // three high/low toggles, no draining
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 5);
      drive(1'b0, 1'b0, 1'b0, 5);
    end
    check("toggles both evt_cnt", 32'(d_cnt[1]), 32'd6);
    check("toggles rise evt_cnt", 32'(d_cnt[0]), 32'd3);

    // drain with one extra ready
    drive(1'b0, 1'b1, 1'b0, 7);
    check("drain evt_cnt",   32'(d_cnt[1]),   32'd0);
    check("drain evt_valid", 32'(d_valid[1]), 32'd0);

    // simultaneous inc/dec at count 2
    drive(1'b1, 1'b0, 1'b0, 5);
    drive(1'b0, 1'b0, 1'b0, 5);
    drive(1'b1, 1'b0, 1'b0, 3);
    drive(1'b1, 1'b1, 1'b0, 1);
    drive(1'b1, 1'b0, 1'b0, 2);
    check("incdec both evt_cnt", 32'(d_cnt[1]), 32'd2);
    check("incdec rise evt_cnt", 32'(d_cnt[0]), 32'd1);
    check("incdec overflow",     32'(d_ovf[1]), 32'd0);

    // randomized segments
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 15) == 0), $urandom_range(1, 6));
    end

    // saturation
    drive(1'b0, 1'b1, 1'b0, 25);
    drive(1'b0, 1'b0, 1'b1, 1);
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 1'b0, 4);
      drive(1'b0, 1'b0, 1'b0, 4);
    end
    check("sat evt_cnt",  32'(d_cnt[0]), 32'd15);
    check("sat overflow", 32'(d_ovf[0]), 32'd1);
    drive(1'b1, 1'b0, 1'b0, 3);
    drive(1'b1, 1'b0, 1'b1, 1);
    check("sat set-wins overflow", 32'(d_ovf[0]), 32'd1);
    drive(1'b1, 1'b0, 1'b1, 1);
    check("sat clear overflow", 32'(d_ovf[0]), 32'd0);

    // reset mid-operation
    drive(1'b0, 1'b1, 1'b0, 25);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b0, 4);
      drive(1'b0, 1'b0, 1'b0, 4);
    end
    check("pre-reset evt_cnt", 32'(d_cnt[0]), 32'd5);
    drive(1'b1, 1'b0, 1'b0, 1);
    @(negedge clk_fast);
    #1 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset dut%0d level_filt", d), 32'(d_lvl[d]),   32'd0);
      check($sformatf("reset dut%0d pulses", d), 32'(d_rise[d] | d_fall[d]), 32'd0);
      check($sformatf("reset dut%0d evt_cnt", d),    32'(d_cnt[d]),   32'd0);
      check($sformatf("reset dut%0d evt_valid", d),  32'(d_valid[d]), 32'd0);
      check($sformatf("reset dut%0d overflow", d),   32'(d_ovf[d]),   32'd0);
    end
    @(posedge clk_fast);
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk_fast);
    #1;
    check("post-reset level_filt", 32'(d_lvl[0]),  32'd1);
    check("post-reset rise_pulse", 32'(d_rise[0]), 32'd1);
    #1;
    drive(1'b1, 1'b0, 1'b0, 3);

    done = 1'b1;
    repeat (2) @(negedge clk_fast);
    check("queue drained dut0", 32'(q0.size()), 32'd0);
    check("queue drained dut1", 32'(q1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_sync_pulse_capture
